// File: rtl/debug_loader_unit_if.sv
// Host-side bus between the debug loader and its UART / instruction-memory / core neighbours.
// The slave modport is the loader's view; the master modport is the environment driving it.
interface debug_loader_unit_if #(
    parameter int NB_DATA       = 32,
    parameter int NB_BYTE       = 8,
    parameter int NB_INSTR_ADDR = 10,
    parameter int NB_CYCLE_CNT  = 32
);
    logic [NB_BYTE-1:0]       i_rx_data;
    logic                     i_rx_valid;
    logic                     i_halt_detected;
    logic                     i_tx_ready;
    logic [NB_BYTE-1:0]       o_tx_data;
    logic                     o_tx_valid;
    logic                     o_prog_wr_enb;
    logic [NB_INSTR_ADDR-1:0] o_prog_wr_addr;
    logic [NB_DATA-1:0]       o_prog_wr_data;
    logic                     o_mips_enable;
    logic                     o_mips_reset;
    logic [NB_CYCLE_CNT-1:0]  o_cycle_count;
    logic [2:0]               o_state;

    modport slave (
        input  i_rx_data, i_rx_valid, i_halt_detected, i_tx_ready,
        output o_tx_data, o_tx_valid, o_prog_wr_enb, o_prog_wr_addr, o_prog_wr_data,
               o_mips_enable, o_mips_reset, o_cycle_count, o_state
    );

    modport master (
        output i_rx_data, i_rx_valid, i_halt_detected, i_tx_ready,
        input  o_tx_data, o_tx_valid, o_prog_wr_enb, o_prog_wr_addr, o_prog_wr_data,
               o_mips_enable, o_mips_reset, o_cycle_count, o_state
    );
endinterface

// File: rtl/debug_loader_unit.sv
// Host command front end for the mips core: loads program words from UART bytes, runs or
// single-steps the core through its enable, and reports the enabled-cycle count back over TX.
module debug_loader_unit #(
    parameter int NB_DATA       = 32,
    parameter int NB_BYTE       = 8,
    parameter int NB_INSTR_ADDR = 10,
    parameter int NB_CYCLE_CNT  = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    debug_loader_unit_if.slave      bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LD_CNT  = 3'd1;
    localparam logic [2:0] ST_LD_WORD = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_STEP    = 3'd4;
    localparam logic [2:0] ST_SEND    = 3'd5;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);

    logic [2:0]               state_reg, state_next;
    logic [1:0]               byte_idx_reg, byte_idx_next;
    logic [15:0]              word_cnt_reg, word_cnt_next;
    logic [15:0]              word_idx_reg, word_idx_next;
    logic [NB_DATA-1:0]       word_buf_reg, word_buf_next;
    logic                     wr_enb_reg, wr_enb_next;
    logic [NB_INSTR_ADDR-1:0] wr_addr_reg, wr_addr_next;
    logic [NB_DATA-1:0]       wr_data_reg, wr_data_next;
    logic                     enable_reg, enable_next;
    logic                     mips_reset_reg, mips_reset_next;
    logic                     halted_reg, halted_next;
    logic [NB_CYCLE_CNT-1:0]  count_reg, count_next;
    logic [NB_CYCLE_CNT-1:0]  snap_reg, snap_next;
    logic [NB_BYTE-1:0]       tx_data_reg, tx_data_next;
    logic                     tx_valid_reg, tx_valid_next;
    logic [1:0]               tx_idx_reg, tx_idx_next;

    logic [NB_BYTE-1:0]       rx_byte;
    logic                     rx_fire;
    logic                     tx_fire;
    logic                     last_word;
    logic [NB_CYCLE_CNT-1:0]  count_inc;
    logic [NB_BYTE-1:0]       inc_bytes  [4];
    logic [NB_BYTE-1:0]       snap_bytes [4];

    assign rx_byte   = bus.i_rx_data;
    assign rx_fire   = bus.i_rx_valid;
    assign tx_fire   = tx_valid_reg && bus.i_tx_ready;
    assign last_word = (word_idx_reg + 16'd1) == word_cnt_reg;
    // Count reflects this cycle's enable, so a snapshot taken on entry to SEND includes it.
    assign count_inc = (enable_reg && (count_reg != '1)) ? count_reg + 1'b1 : count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign inc_bytes[gi]  = count_inc[gi*NB_BYTE +: NB_BYTE];
            assign snap_bytes[gi] = snap_reg[gi*NB_BYTE +: NB_BYTE];
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (rx_byte == CMD_LOAD)      state_next = ST_LD_CNT;
                    else if (rx_byte == CMD_RUN)  state_next = halted_reg ? ST_SEND : ST_RUN;
                    else if (rx_byte == CMD_STEP) state_next = halted_reg ? ST_SEND : ST_STEP;
                end
            end
            ST_LD_CNT: begin
                if (rx_fire && byte_idx_reg == 2'd1)
                    state_next = ({rx_byte, word_cnt_reg[7:0]} == 16'd0) ? ST_IDLE : ST_LD_WORD;
            end
            ST_LD_WORD: begin
                if (rx_fire && byte_idx_reg == 2'd3 && last_word) state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (enable_reg && bus.i_halt_detected) state_next = ST_SEND;
            end
            ST_STEP: state_next = ST_SEND;
            ST_SEND: begin
                if (tx_fire && tx_idx_reg == 2'd3) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_idx_next   = byte_idx_reg;
        word_cnt_next   = word_cnt_reg;
        word_idx_next   = word_idx_reg;
        word_buf_next   = word_buf_reg;
        wr_enb_next     = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        enable_next     = enable_reg;
        mips_reset_next = mips_reset_reg;
        halted_next     = halted_reg;
        count_next      = count_inc;
        snap_next       = snap_reg;
        tx_data_next    = tx_data_reg;
        tx_valid_next   = tx_valid_reg;
        tx_idx_next     = tx_idx_reg;

        case (state_reg)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (rx_byte == CMD_LOAD) begin
                        mips_reset_next = 1'b1;
                        count_next      = '0;
                        halted_next     = 1'b0;
                        word_idx_next   = '0;
                        byte_idx_next   = '0;
                    end else if ((rx_byte == CMD_RUN || rx_byte == CMD_STEP) && !halted_reg) begin
                        enable_next     = 1'b1;
                        mips_reset_next = 1'b0;
                    end
                end
            end
            ST_LD_CNT: begin
                if (rx_fire) begin
                    if (byte_idx_reg == 2'd0) begin
                        word_cnt_next[7:0] = rx_byte;
                        byte_idx_next      = 2'd1;
                    end else begin
                        word_cnt_next = {rx_byte, word_cnt_reg[7:0]};
                        byte_idx_next = 2'd0;
                    end
                end
            end
            ST_LD_WORD: begin
                if (rx_fire) begin
                    word_buf_next[{byte_idx_reg, 3'b000} +: NB_BYTE] = rx_byte;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        // Address is the low bits of the index, so long loads wrap onto word 0.
                        wr_enb_next   = 1'b1;
                        wr_addr_next  = word_idx_reg[NB_INSTR_ADDR-1:0];
                        wr_data_next  = {rx_byte, word_buf_reg[NB_DATA-NB_BYTE-1:0]};
                        word_idx_next = word_idx_reg + 16'd1;
                    end
                end
            end
            ST_RUN: begin
                if (enable_reg && bus.i_halt_detected) begin
                    enable_next = 1'b0;
                    halted_next = 1'b1;
                end
            end
            ST_STEP: begin
                enable_next = 1'b0;
                if (bus.i_halt_detected) halted_next = 1'b1;
            end
            ST_SEND: begin
                if (tx_fire) begin
                    if (tx_idx_reg == 2'd3) begin
                        tx_valid_next = 1'b0;
                    end else begin
                        tx_idx_next  = tx_idx_reg + 2'd1;
                        tx_data_next = snap_bytes[tx_idx_reg + 2'd1];
                    end
                end
            end
            default: ;
        endcase

        if (state_next == ST_SEND && state_reg != ST_SEND) begin
            snap_next     = count_inc;
            tx_data_next  = inc_bytes[0];
            tx_valid_next = 1'b1;
            tx_idx_next   = 2'd0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            byte_idx_reg   <= '0;
            word_cnt_reg   <= '0;
            word_idx_reg   <= '0;
            word_buf_reg   <= '0;
            wr_enb_reg     <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            enable_reg     <= 1'b0;
            mips_reset_reg <= 1'b1;
            halted_reg     <= 1'b0;
            count_reg      <= '0;
            snap_reg       <= '0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            tx_idx_reg     <= '0;
        end else begin
            byte_idx_reg   <= byte_idx_next;
            word_cnt_reg   <= word_cnt_next;
            word_idx_reg   <= word_idx_next;
            word_buf_reg   <= word_buf_next;
            wr_enb_reg     <= wr_enb_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            enable_reg     <= enable_next;
            mips_reset_reg <= mips_reset_next;
            halted_reg     <= halted_next;
            count_reg      <= count_next;
            snap_reg       <= snap_next;
            tx_data_reg    <= tx_data_next;
            tx_valid_reg   <= tx_valid_next;
            tx_idx_reg     <= tx_idx_next;
        end
    end

    assign bus.o_tx_data      = tx_data_reg;
    assign bus.o_tx_valid     = tx_valid_reg;
    assign bus.o_prog_wr_enb  = wr_enb_reg;
    assign bus.o_prog_wr_addr = wr_addr_reg;
    assign bus.o_prog_wr_data = wr_data_reg;
    assign bus.o_mips_enable  = enable_reg;
    assign bus.o_mips_reset   = mips_reset_reg;
    assign bus.o_cycle_count  = count_reg;
    assign bus.o_state        = state_reg;
endmodule

// File: tb/tb_debug_loader_unit.sv
// Scoreboard bench for debug_loader_unit: directed host command sequences push expected
// memory writes and TX bytes; a negedge monitor pops and compares them as the DUT emits.
module tb_debug_loader_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    debug_loader_unit_if bus ();

    debug_loader_unit dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int         tests = 0;
    int         fails = 0;
    int         en_cycles = 0;
    int         ready_mode = 1;   // 0 low, 1 high, 2 toggle
    bit         load_phase = 0;
    bit         rst_low_seen = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.i_tx_ready = 1'b0;
            1:       bus.i_tx_ready = 1'b1;
            default: bus.i_tx_ready = ~bus.i_tx_ready;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (bus.o_mips_enable) en_cycles++;
            if (load_phase && !bus.o_mips_reset) rst_low_seen = 1;
            if (bus.o_prog_wr_enb) begin
                if (wr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wr_unexpected: addr=0x%0h data=0x%0h, expected no write",
                             bus.o_prog_wr_addr, bus.o_prog_wr_data);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("wr_addr", 64'(bus.o_prog_wr_addr), 64'(w.addr));
                    check("wr_data", 64'(bus.o_prog_wr_data), 64'(w.data));
                end
            end
            if (prev_stall)
                check("tx_hold", {55'd0, bus.o_tx_valid, bus.o_tx_data}, {55'd0, 1'b1, prev_data});
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (tx_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL tx_unexpected: byte=0x%0h, expected none", bus.o_tx_data);
                end else begin
                    check("tx_byte", 64'(bus.o_tx_data), 64'(tx_q.pop_front()));
                end
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic push_report(input logic [31:0] v);
        for (int i = 0; i < 4; i++) tx_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.o_state !== 3'd0 || tx_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 64'(bus.o_state), 64'd0);
        check({name, "_tx_drained"}, 64'(tx_q.size()), 64'd0);
    endtask

    task automatic load_t1(input string tag);
        logic [7:0] seq [11];
        seq = '{8'h4C, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_wr(10'd0, 32'h12345678);
        push_wr(10'd1, 32'hDEADBEEF);
        rst_low_seen = 0;
        send(seq[0]);
        load_phase = 1;
        for (int i = 1; i < 11; i++) send(seq[i]);
        tick();
        tick();
        load_phase = 0;
        check({tag, "_writes_done"}, 64'(wr_q.size()), 64'd0);
        check({tag, "_mips_reset_held"}, 64'(rst_low_seen), 64'd0);
        check({tag, "_idle"}, 64'(bus.o_state), 64'd0);
        check({tag, "_count_cleared"}, 64'(bus.o_cycle_count), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 64'(bus.o_state), 64'd0);
        check({tag, "_mips_reset"}, 64'(bus.o_mips_reset), 64'd1);
        check({tag, "_enable"}, 64'(bus.o_mips_enable), 64'd0);
        check({tag, "_wr_enb"}, 64'(bus.o_prog_wr_enb), 64'd0);
        check({tag, "_tx_valid"}, 64'(bus.o_tx_valid), 64'd0);
        check({tag, "_tx_data"}, 64'(bus.o_tx_data), 64'd0);
        check({tag, "_count"}, 64'(bus.o_cycle_count), 64'd0);
        check({tag, "_wr_data"}, 64'(bus.o_prog_wr_data), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_rx_data       = '0;
        bus.i_rx_valid      = 1'b0;
        bus.i_halt_detected = 1'b0;
        bus.i_tx_ready      = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_values("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // T1: two-word load
        load_t1("t1");

        // T2: run until halt in the 10th enabled cycle, TX ready toggling
        ready_mode = 2;
        en_cycles  = 0;
        push_report(32'd10);
        send(8'h52);
        check("t2_enable_on", 64'(bus.o_mips_enable), 64'd1);
        check("t2_mips_reset_off", 64'(bus.o_mips_reset), 64'd0);
        repeat (9) tick();
        bus.i_halt_detected = 1'b1;
        tick();
        bus.i_halt_detected = 1'b0;
        check("t2_enable_off", 64'(bus.o_mips_enable), 64'd0);
        wait_idle("t2", 200);
        check("t2_enabled_cycles", 64'(en_cycles), 64'd10);
        check("t2_count", 64'(bus.o_cycle_count), 64'd10);
        ready_mode = 1;

        // T4: halted core, 'R' reports without pulsing enable
        en_cycles = 0;
        push_report(32'd10);
        send(8'h52);
        wait_idle("t4", 200);
        check("t4_enabled_cycles", 64'(en_cycles), 64'd0);
        load_t1("t4_reload");

        // T3: three single steps
        for (int k = 1; k <= 3; k++) begin
            en_cycles = 0;
            push_report(32'(k));
            send(8'h53);
            wait_idle($sformatf("t3_step%0d", k), 200);
            check($sformatf("t3_step%0d_enabled_cycles", k), 64'(en_cycles), 64'd1);
            check($sformatf("t3_step%0d_count", k), 64'(bus.o_cycle_count), 64'(k));
        end

        // T5: N=0 load, ignored byte, N=1025 wrapping load
        send(8'h4C);
        send(8'h00);
        send(8'h00);
        tick();
        check("t5_n0_idle", 64'(bus.o_state), 64'd0);
        send(8'h41);
        tick();
        check("t5_ignored_idle", 64'(bus.o_state), 64'd0);
        send(8'h4C);
        send(8'h01);
        send(8'h04);
        for (int i = 0; i < 1025; i++) begin
            logic [31:0] d;
            d = 32'hC0DE0000 + 32'(i);
            push_wr(10'(i), d);
            for (int j = 0; j < 4; j++) send(d[j*8 +: 8]);
        end
        tick();
        tick();
        check("t5_writes_done", 64'(wr_q.size()), 64'd0);
        check("t5_last_addr", 64'(bus.o_prog_wr_addr), 64'd0);
        check("t5_last_data", 64'(bus.o_prog_wr_data), 64'hC0DE0400);
        check("t5_idle", 64'(bus.o_state), 64'd0);

        // T6: reset mid-LD_WORD, then mid-SEND
        send(8'h4C);
        send(8'h01);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        rst = 1'b1;
        #1 check("t6a_state", 64'(bus.o_state), 64'd0);
        check("t6a_mips_reset", 64'(bus.o_mips_reset), 64'd1);
        check("t6a_wr_enb", 64'(bus.o_prog_wr_enb), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        load_t1("t6a_fresh");

        ready_mode = 0;
        send(8'h53);
        for (int n = 0; n < 20 && !bus.o_tx_valid; n++) tick();
        check("t6b_in_send", 64'(bus.o_tx_valid), 64'd1);
        rst = 1'b1;
        #1 check("t6b_tx_valid", 64'(bus.o_tx_valid), 64'd0);
        check("t6b_state", 64'(bus.o_state), 64'd0);
        check("t6b_mips_reset", 64'(bus.o_mips_reset), 64'd1);
        check("t6b_count", 64'(bus.o_cycle_count), 64'd0);
        tick();
        rst = 1'b0;
        ready_mode = 1;
        tick();
        load_t1("t6b_fresh");
        en_cycles = 0;
        push_report(32'd1);
        send(8'h53);
        wait_idle("t6b_step", 200);
        check("t6b_step_enabled_cycles", 64'(en_cycles), 64'd1);

        tick();
        check("end_wr_q_empty", 64'(wr_q.size()), 64'd0);
        check("end_tx_q_empty", 64'(tx_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
